// File: rtl/rast_perf_counter.sv
// Passive performance monitor for the rasterizer sample-test (R16) and hit (R18) stages.
// Accumulates saturating cycle, triangle, sample, hit and orphan-hit counts.
module rast_perf_counter #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R16S       [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R16U     [COLORS],
  input  logic                     validSamp_R16H,
  input  logic signed [SIGFIG-1:0] sample_R16S    [2],
  input  logic signed [SIGFIG-1:0] hit_R18S       [AXIS],
  input  logic        [SIGFIG-1:0] color_R18U     [COLORS],
  input  logic                     hit_valid_R18H,
  output logic        [CNT_W-1:0]  cycle_count,
  output logic        [CNT_W-1:0]  triangle_count,
  output logic        [CNT_W-1:0]  sample_count,
  output logic        [CNT_W-1:0]  sample_hit_count,
  output logic        [CNT_W-1:0]  orphan_hit_count
);

  localparam int NUM_CNT = 5;

  logic signed [SIGFIG-1:0] last_tri_reg [VERTS][AXIS];
  logic                     have_tri_reg;
  logic [PIPE_DEPTH-1:0]    samp_hist_reg;
  logic [VERTS*AXIS-1:0]    word_diff;
  logic                     new_tri;
  logic                     recent_samp;
  logic [NUM_CNT-1:0]       cnt_inc;
  logic [CNT_W-1:0]         cnt_reg [NUM_CNT];

  // One mismatch flag per vertex coordinate word.
  genvar gi, gj;
  generate
    for (gi = 0; gi < VERTS; gi++) begin : g_vert
      for (gj = 0; gj < AXIS; gj++) begin : g_axis
        assign word_diff[gi*AXIS+gj] = (tri_R16S[gi][gj] != last_tri_reg[gi][gj]);
      end
    end
  endgenerate

  assign new_tri     = validSamp_R16H && (!have_tri_reg || (|word_diff));
  // History is sampled before this edge's shift.
  assign recent_samp = |samp_hist_reg;

  assign cnt_inc = {hit_valid_R18H && !recent_samp,
                    hit_valid_R18H,
                    validSamp_R16H,
                    new_tri,
                    1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_tri_reg  <= 1'b0;
      samp_hist_reg <= '0;
      for (int v = 0; v < VERTS; v++)
        for (int a = 0; a < AXIS; a++)
          last_tri_reg[v][a] <= '0;
    end else begin
      samp_hist_reg <= {samp_hist_reg[PIPE_DEPTH-2:0], validSamp_R16H};
      if (new_tri) begin
        have_tri_reg <= 1'b1;
        last_tri_reg <= tri_R16S;
      end
    end
  end

  // Saturating counters: 0 cycle, 1 triangle, 2 sample, 3 hit, 4 orphan.
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg[gi] <= '0;
        else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  endgenerate

  assign cycle_count      = cnt_reg[0];
  assign triangle_count   = cnt_reg[1];
  assign sample_count     = cnt_reg[2];
  assign sample_hit_count = cnt_reg[3];
  assign orphan_hit_count = cnt_reg[4];

endmodule

// File: tb/tb_rast_perf_counter.sv
// Directed bench for rast_perf_counter: full-width instance plus a CNT_W=4 instance
// sharing the same stimulus to exercise saturation.
module tb_rast_perf_counter;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [SIGFIG-1:0] tri_v     [VERTS][AXIS];
  logic        [SIGFIG-1:0] color16_v [COLORS];
  logic                     valid_samp = 1'b0;
  logic signed [SIGFIG-1:0] sample_v  [2];
  logic signed [SIGFIG-1:0] hit_v     [AXIS];
  logic        [SIGFIG-1:0] color18_v [COLORS];
  logic                     hit_valid = 1'b0;

  logic [31:0] cyc_c, tri_c, samp_c, hit_c, orph_c;
  logic [3:0]  s_cyc_c, s_tri_c, s_samp_c, s_hit_c, s_orph_c;

  int n_vec = 0;
  int n_bad = 0;
  int exp_cyc = 0;

  always #5 clk = ~clk;

  rast_perf_counter dut (
    .clk(clk), .rst(rst),
    .tri_R16S(tri_v), .color_R16U(color16_v), .validSamp_R16H(valid_samp),
    .sample_R16S(sample_v), .hit_R18S(hit_v), .color_R18U(color18_v),
    .hit_valid_R18H(hit_valid),
    .cycle_count(cyc_c), .triangle_count(tri_c), .sample_count(samp_c),
    .sample_hit_count(hit_c), .orphan_hit_count(orph_c)
  );

  rast_perf_counter #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .tri_R16S(tri_v), .color_R16U(color16_v), .validSamp_R16H(valid_samp),
    .sample_R16S(sample_v), .hit_R18S(hit_v), .color_R18U(color18_v),
    .hit_valid_R18H(hit_valid),
    .cycle_count(s_cyc_c), .triangle_count(s_tri_c), .sample_count(s_samp_c),
    .sample_hit_count(s_hit_c), .orphan_hit_count(s_orph_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance n rising edges; inputs and outputs change/settle 1 time unit after each edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_cyc++;
    end
  endtask

  // Triangle words are base+index; delta is added to the final word only.
  task automatic set_tri(input int base, input int delta);
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_v[v][a] = SIGFIG'(base + v*AXIS + a);
    tri_v[VERTS-1][AXIS-1] = tri_v[VERTS-1][AXIS-1] + SIGFIG'(delta);
  endtask

  task automatic check_all(input string tag, input int c, input int t, input int s,
                           input int h, input int o);
    check_eq({tag, ".cycle"},  cyc_c,  32'(c));
    check_eq({tag, ".tri"},    tri_c,  32'(t));
    check_eq({tag, ".samp"},   samp_c, 32'(s));
    check_eq({tag, ".hit"},    hit_c,  32'(h));
    check_eq({tag, ".orphan"}, orph_c, 32'(o));
  endtask

  initial begin
    set_tri(100, 0);
    for (int i = 0; i < COLORS; i++) begin
      color16_v[i] = SIGFIG'(i);
      color18_v[i] = SIGFIG'(i + 7);
    end
    sample_v[0] = 24'sd5;
    sample_v[1] = 24'sd6;
    for (int i = 0; i < AXIS; i++) hit_v[i] = SIGFIG'(i + 3);

    // Reset held over a few edges, released between edges.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;
    exp_cyc = 0;

    // 100 idle cycles.
    step(100);
    check_all("idle", 100, 0, 0, 0, 0);
    check_eq("small.cycle_sat", 32'(s_cyc_c), 32'd15);

    // Constant triangle T1 for 10 samples.
    set_tri(100, 0);
    valid_samp = 1'b1;
    step(10);
    valid_samp = 1'b0;
    check_all("t1x10", 110, 1, 10, 0, 0);

    // T1 x3 (already last), T2 x3, T1 x2 -> two new triangles.
    valid_samp = 1'b1;
    step(3);
    set_tri(100, 1);
    step(3);
    set_tri(100, 0);
    step(2);
    valid_samp = 1'b0;
    check_eq("seq.tri", tri_c, 32'd3);
    check_eq("seq.samp", samp_c, 32'd18);

    // Gap then the same triangle again -> no new triangle.
    step(2);
    valid_samp = 1'b1;
    step(1);
    valid_samp = 1'b0;
    check_eq("gap.tri", tri_c, 32'd3);
    check_eq("gap.samp", samp_c, 32'd19);
    step(10);

    // Sample at cycle 0, hits at cycles 2 and 9 -> only the second is orphaned.
    valid_samp = 1'b1;
    step(1);
    valid_samp = 1'b0;
    step(1);
    hit_valid = 1'b1;
    step(1);
    hit_valid = 1'b0;
    check_eq("hit2.orphan", orph_c, 32'd0);
    step(6);
    hit_valid = 1'b1;
    step(1);
    hit_valid = 1'b0;
    check_all("orphan", exp_cyc, 3, 20, 2, 1);
    step(5);

    // Same edge: new triangle T3, sample and hit with empty history -> hit is orphaned.
    set_tri(500, 0);
    valid_samp = 1'b1;
    hit_valid  = 1'b1;
    step(1);
    valid_samp = 1'b0;
    hit_valid  = 1'b0;
    check_all("simul", exp_cyc, 4, 21, 3, 2);

    // History boundary: hit PIPE_DEPTH edges after a sample is covered, one later is not.
    step(5);
    valid_samp = 1'b1;
    step(1);
    valid_samp = 1'b0;
    step(3);
    hit_valid = 1'b1;
    step(1);
    check_eq("edge4.orphan", orph_c, 32'd2);
    step(1);
    hit_valid = 1'b0;
    check_all("edge5", exp_cyc, 4, 22, 5, 3);

    // Saturation of the narrow instance.
    check_eq("small.cycle", 32'(s_cyc_c), 32'd15);
    check_eq("small.samp",  32'(s_samp_c), 32'd15);
    check_eq("small.tri",   32'(s_tri_c), 32'd4);
    check_eq("small.hit",   32'(s_hit_c), 32'd5);
    check_eq("small.orphan", 32'(s_orph_c), 32'd3);

    // Asynchronous reset pulse between edges.
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    check_eq("small.async_rst", 32'(s_cyc_c), 32'd0);
    #1;
    rst = 1'b0;
    exp_cyc = 0;

    // First sample after reset must count as a new triangle even though T3 matched before.
    valid_samp = 1'b1;
    step(1);
    valid_samp = 1'b0;
    check_all("post_rst", 1, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
